// File: rtl/crtc_pkg.sv
//============================================================================
// Module  : crtc_pkg
// Purpose : Shared command/sequencer encodings, end codes and status layout
//           for the CRTC row fetcher.
// Revision: 1.0
//============================================================================
`default_nettype none

package crtc_pkg;

    typedef enum logic [2:0] {
        CMD_RESET  = 3'b000,
        CMD_START  = 3'b001,
        CMD_STOP   = 3'b010,
        CMD_LDCUR  = 3'b100,
        CMD_INTON  = 3'b101,
        CMD_INTOFF = 3'b110
    } crtc_cmd_e;

    typedef enum logic [2:0] {
        PS_IDLE  = 3'd0,
        PS_COLS  = 3'd1,
        PS_ROWS  = 3'd2,
        PS_HGT   = 3'd3,
        PS_BURST = 3'd4,
        PS_CURX  = 3'd5,
        PS_CURY  = 3'd6
    } crtc_pstate_e;

    localparam logic [7:0] c_end_row   = 8'hF1;
    localparam logic [7:0] c_end_frame = 8'hF3;

    localparam int c_st_inte = 6;
    localparam int c_st_irq  = 5;
    localparam int c_st_err  = 3;
    localparam int c_st_en   = 2;
    localparam int c_st_undr = 1;

    function automatic logic [7:0] burst_len(input logic [2:0] code);
        return 8'd1 << code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/crtc_rowbuf.sv
//============================================================================
// Module  : crtc_rowbuf
// Purpose : Two-bank character row buffer, one write port, one async read.
// Revision: 1.0
//============================================================================
`default_nettype none

module crtc_rowbuf #(
    parameter int DEPTH = 80,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_wbank,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_rbank,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_bank0 [DEPTH];
    logic [7:0] r_bank1 [DEPTH];

    // Contents are don't-care after reset, so the arrays carry no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_wbank) begin
                r_bank1[i_waddr] <= i_wdata;
            end else begin
                r_bank0[i_waddr] <= i_wdata;
            end
        end
    end

    assign o_rdata = i_rbank ? r_bank1[i_raddr] : r_bank0[i_raddr];

endmodule

`default_nettype wire

// File: rtl/crtc_row_fetch.sv
//============================================================================
// Module  : crtc_row_fetch
// Purpose : CRTC row fetcher: command/parameter port, DMA row fill into a
//           double-buffered row store, character/attribute display output.
//           Define CRTC_BURST_EN for burst DMA pacing.
// Revision: 1.0
//============================================================================
`default_nettype none

module crtc_row_fetch
    import crtc_pkg::*;
#(
    parameter int MAX_COLS = 80,
    parameter int MAX_ROWS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_ce,
    input  logic       hrst,
    input  logic       vrst,
    input  logic       a0,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       rd,
    output logic [7:0] rdata,
    output logic       drq,
    input  logic       dack,
    input  logic [7:0] dma_data,
    output logic       irq,
    output logic [7:0] out_char,
    output logic [5:0] out_attr,
    output logic [3:0] out_line,
    output logic       out_valid
);

    localparam int         AW        = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [7:0] c_depth   = 8'(MAX_COLS);
    localparam logic [6:0] c_max_col = 7'(MAX_COLS - 1);
    localparam logic [5:0] c_max_row = 6'(MAX_ROWS - 1);

    logic         r_enable, r_inte, r_irq, r_err, r_underrun;
    crtc_pstate_e r_pstate;
    logic [6:0]   r_cols_m1, r_cur_x;
    logic [5:0]   r_rows_m1, r_cur_y;
    logic [3:0]   r_hgt_m1, r_chline;
    logic [2:0]   r_burst;
    logic         r_fill_bank, r_row_term, r_frame_term;
    logic [7:0]   r_fill_idx, r_disp_len, r_disp_idx;
    logic [6:0]   r_row;
    logic         r_disp_act, r_out_valid;
    logic [7:0]   r_out_char;
    logic [5:0]   r_out_attr;
    logic [7:0]   w_status, w_rd_byte;
    logic [2:0]   w_op;
    logic         w_cmd, w_par, w_cmd_rst, w_hrst, w_vrst, w_swap;
    logic         w_rows_left, w_last_wrap, w_fill_open, w_drq, w_take;
    logic         w_end_row, w_end_frame, w_wr, w_disp_hit;

    assign w_op        = wdata[7:5];
    assign w_cmd       = we && a0;
    assign w_par       = we && !a0;
    assign w_cmd_rst   = w_cmd && (w_op == CMD_RESET);
    assign w_hrst      = char_ce && hrst;
    assign w_vrst      = char_ce && vrst;
    assign w_swap      = w_hrst && !w_vrst && (r_chline == r_hgt_m1);
    assign w_rows_left = (r_row <= {1'b0, r_rows_m1});
    assign w_last_wrap = (r_row == ({1'b0, r_rows_m1} + 7'd1));
    assign w_fill_open = r_enable && (r_fill_idx <= {1'b0, r_cols_m1})
                         && !r_row_term && !r_frame_term && w_rows_left;
    assign w_take      = char_ce && w_drq && dack;
    assign w_end_row   = (dma_data == c_end_row);
    assign w_end_frame = (dma_data == c_end_frame);
    assign w_wr        = w_take && !w_end_row && !w_end_frame && (r_fill_idx < c_depth);
    assign w_disp_hit  = (r_disp_idx < r_disp_len);

    // Command decode and parameter sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable  <= 1'b0;
            r_inte    <= 1'b0;
            r_pstate  <= PS_IDLE;
            r_cols_m1 <= '0;
            r_rows_m1 <= '0;
            r_hgt_m1  <= '0;
            r_burst   <= '0;
            r_cur_x   <= '0;
            r_cur_y   <= '0;
        end else if (w_cmd) begin
            case (w_op)
                CMD_RESET:  begin r_enable <= 1'b0; r_pstate <= PS_COLS; end
                CMD_START:  begin r_enable <= 1'b1; r_inte <= 1'b1; end
                CMD_STOP:   r_enable <= 1'b0;
                CMD_LDCUR:  r_pstate <= PS_CURX;
                CMD_INTON:  r_inte <= 1'b1;
                CMD_INTOFF: r_inte <= 1'b0;
                default:    ;
            endcase
        end else if (w_par) begin
            case (r_pstate)
                PS_COLS: begin
                    r_cols_m1 <= (wdata[6:0] > c_max_col) ? c_max_col : wdata[6:0];
                    r_pstate  <= PS_ROWS;
                end
                PS_ROWS: begin
                    r_rows_m1 <= (wdata[5:0] > c_max_row) ? c_max_row : wdata[5:0];
                    r_pstate  <= PS_HGT;
                end
                PS_HGT:   begin r_hgt_m1 <= wdata[3:0]; r_pstate <= PS_BURST; end
                PS_BURST: begin r_burst  <= wdata[2:0]; r_pstate <= PS_IDLE; end
                PS_CURX:  begin r_cur_x  <= wdata[6:0]; r_pstate <= PS_CURY; end
                PS_CURY:  begin r_cur_y  <= wdata[5:0]; r_pstate <= PS_IDLE; end
                default:  r_pstate <= PS_IDLE;
            endcase
        end
    end

    // Sticky status: a set event in the same cycle as rd wins over the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq      <= 1'b0;
            r_err      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_swap && w_last_wrap && r_inte) r_irq <= 1'b1;
            else if (rd)                         r_irq <= 1'b0;
            if (w_par && (r_pstate == PS_IDLE))  r_err <= 1'b1;
            else if (rd)                         r_err <= 1'b0;
            if (w_swap && w_fill_open)           r_underrun <= 1'b1;
            else if (rd)                         r_underrun <= 1'b0;
        end
    end

    always_comb begin
        w_status            = '0;
        w_status[c_st_inte] = r_inte;
        w_status[c_st_irq]  = r_irq;
        w_status[c_st_err]  = r_err;
        w_status[c_st_en]   = r_enable;
        w_status[c_st_undr] = r_underrun;
    end

    // Fill side, bank swap, character line and row counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill_bank  <= 1'b0;
            r_fill_idx   <= '0;
            r_row_term   <= 1'b0;
            r_frame_term <= 1'b0;
            r_disp_len   <= '0;
            r_row        <= '0;
            r_chline     <= '0;
        end else begin
            if (w_cmd_rst) begin
                r_fill_idx   <= '0;
                r_row_term   <= 1'b0;
                r_frame_term <= 1'b0;
                r_disp_len   <= '0;
            end else if (w_vrst) begin
                r_fill_idx   <= '0;
                r_row_term   <= 1'b0;
                r_frame_term <= 1'b0;
            end else if (w_swap) begin
                r_fill_bank <= ~r_fill_bank;
                r_fill_idx  <= '0;
                r_row_term  <= 1'b0;
                r_disp_len  <= r_fill_idx;
            end else if (w_take) begin
                if (w_end_row)        r_row_term   <= 1'b1;
                else if (w_end_frame) r_frame_term <= 1'b1;
                else                  r_fill_idx   <= r_fill_idx + 8'd1;
            end

            if (w_vrst) begin
                r_chline <= '0;
                r_row    <= '0;
            end else if (w_hrst) begin
                if (r_chline == r_hgt_m1) begin
                    r_chline <= '0;
                    if (r_row != 7'h7F) r_row <= r_row + 7'd1;
                end else begin
                    r_chline <= r_chline + 4'd1;
                end
            end
        end
    end

`ifdef CRTC_BURST_EN
    logic [7:0] r_bcnt;
    logic [3:0] r_wait;

    assign w_drq = w_fill_open && (r_wait == 4'd0);

    always_ff @(posedge clk) begin
        if (reset || w_cmd_rst) begin
            r_bcnt <= '0;
            r_wait <= '0;
        end else if (char_ce) begin
            if (w_take) begin
                if ((r_bcnt + 8'd1) == burst_len(r_burst)) begin
                    r_bcnt <= '0;
                    r_wait <= 4'd8;
                end else begin
                    r_bcnt <= r_bcnt + 8'd1;
                end
            end else if (r_wait != 4'd0) begin
                r_wait <= r_wait - 4'd1;
            end
        end
    end
`else
    logic r_gap;

    assign w_drq = w_fill_open && !r_gap;

    always_ff @(posedge clk) begin
        if (reset || w_cmd_rst) begin
            r_gap <= 1'b0;
        end else if (char_ce) begin
            r_gap <= w_take;
        end
    end
`endif

    crtc_rowbuf #(
        .DEPTH (MAX_COLS),
        .AW    (AW)
    ) u_rowbuf (
        .clk     (clk),
        .i_we    (w_wr),
        .i_wbank (r_fill_bank),
        .i_waddr (r_fill_idx[AW-1:0]),
        .i_wdata (dma_data),
        .i_rbank (~r_fill_bank),
        .i_raddr (r_disp_idx[AW-1:0]),
        .o_rdata (w_rd_byte)
    );

    // Display side: hrst arms a scan of cols slots from the display bank
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_idx  <= '0;
            r_disp_act  <= 1'b0;
            r_out_char  <= '0;
            r_out_attr  <= '0;
            r_out_valid <= 1'b0;
        end else if (char_ce) begin
            if (hrst) begin
                r_disp_idx  <= '0;
                r_disp_act  <= r_enable;
                r_out_char  <= '0;
                r_out_valid <= 1'b0;
            end else if (r_disp_act && (r_disp_idx <= {1'b0, r_cols_m1})) begin
                r_disp_idx  <= r_disp_idx + 8'd1;
                r_out_valid <= 1'b1;
                if (w_disp_hit && (w_rd_byte[7:6] != 2'b10)) r_out_char <= w_rd_byte;
                else                                          r_out_char <= '0;
                if (w_disp_hit && (w_rd_byte[7:6] == 2'b10)) r_out_attr <= w_rd_byte[5:0];
            end else begin
                r_disp_act  <= 1'b0;
                r_out_char  <= '0;
                r_out_valid <= 1'b0;
            end
            if (vrst) begin
                r_out_attr <= '0;
                if (!hrst) begin
                    r_disp_act <= 1'b0;
                    r_disp_idx <= '0;
                end
            end
        end
    end

    assign rdata     = w_status;
    assign drq       = w_drq;
    assign irq       = r_irq;
    assign out_char  = r_out_char;
    assign out_attr  = r_out_attr;
    assign out_line  = r_chline;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_crtc_row_fetch.sv
//============================================================================
// Module  : tb_crtc_row_fetch
// Purpose : Directed self-checking bench for crtc_row_fetch.
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_crtc_row_fetch;

    logic       clk = 1'b0;
    logic       reset, char_ce, hrst, vrst, a0, we, rd, dack;
    logic [7:0] wdata, dma_data;
    logic [7:0] rdata, out_char;
    logic [5:0] out_attr;
    logic [3:0] out_line;
    logic       drq, irq, out_valid;

    int n_vec = 0;
    int n_err = 0;

    crtc_row_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .char_ce   (char_ce),
        .hrst      (hrst),
        .vrst      (vrst),
        .a0        (a0),
        .wdata     (wdata),
        .we        (we),
        .rd        (rd),
        .rdata     (rdata),
        .drq       (drq),
        .dack      (dack),
        .dma_data  (dma_data),
        .irq       (irq),
        .out_char  (out_char),
        .out_attr  (out_attr),
        .out_line  (out_line),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic cmd, input logic [7:0] d);
        a0 = cmd; wdata = d; we = 1'b1;
        tick();
        we = 1'b0; a0 = 1'b0;
    endtask

    task automatic pulse_hrst(input int n);
        repeat (n) begin
            hrst = 1'b1;
            tick();
            hrst = 1'b0;
        end
    endtask

    task automatic pulse_vrst();
        hrst = 1'b1; vrst = 1'b1;
        tick();
        hrst = 1'b0; vrst = 1'b0;
    endtask

    task automatic do_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; char_ce = 1'b1; hrst = 1'b0; vrst = 1'b0; a0 = 1'b0;
        we = 1'b0; rd = 1'b0; dack = 1'b0; wdata = '0; dma_data = '0;
        repeat (3) tick();
        n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        n_vec++; if (drq !== 1'b0) begin n_err++; $display("FAIL reset_drq: got %b expected 0", drq); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_vec++; if (out_char !== 8'h00) begin n_err++; $display("FAIL reset_char: got %h expected 00", out_char); end
        n_vec++; if (out_attr !== 6'h00) begin n_err++; $display("FAIL reset_attr: got %h expected 00", out_attr); end
        n_vec++; if (out_line !== 4'h0) begin n_err++; $display("FAIL reset_line: got %h expected 0", out_line); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_program();
        cpu_wr(1'b1, 8'h00);
        cpu_wr(1'b0, 8'h4F);
        cpu_wr(1'b0, 8'h1D);
        cpu_wr(1'b0, 8'h99);
        cpu_wr(1'b0, 8'h03);
        n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL prog_status: got %h expected 00", rdata); end
        cpu_wr(1'b1, 8'h20);
        n_vec++; if (rdata !== 8'h44) begin n_err++; $display("FAIL start_status: got %h expected 44", rdata); end
        n_vec++; if (drq !== 1'b1) begin n_err++; $display("FAIL start_drq: got %b expected 1", drq); end
    endtask

    task automatic test_fill_display();
        int n;
        char_ce = 1'b0; hrst = 1'b1;
        tick();
        hrst = 1'b0; char_ce = 1'b1;
        n_vec++; if (out_line !== 4'h0) begin n_err++; $display("FAIL ce_gate_line: got %h expected 0", out_line); end
        dack = 1'b1; dma_data = 8'h41; n = 0;
        for (int c = 0; c < 1000 && n < 80; c++) begin
            if (drq) n++;
            tick();
        end
        dack = 1'b0;
        n_vec++; if (n !== 80) begin n_err++; $display("FAIL fill_count: got %0d expected 80", n); end
        n_vec++; if (drq !== 1'b0) begin n_err++; $display("FAIL fill_full_drq: got %b expected 0", drq); end
        pulse_hrst(9);
        n_vec++; if (out_line !== 4'h9) begin n_err++; $display("FAIL line_9: got %h expected 9", out_line); end
        pulse_hrst(1);
        n_vec++; if (out_line !== 4'h0) begin n_err++; $display("FAIL line_wrap: got %h expected 0", out_line); end
        n_vec++; if (rdata[1] !== 1'b0) begin n_err++; $display("FAIL full_underrun: got %b expected 0", rdata[1]); end
        for (int col = 0; col < 80; col++) begin
            tick();
            n_vec++;
            if (out_char !== 8'h41 || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL row41 col %0d: got %h/%b expected 41/1", col, out_char, out_valid);
            end
        end
        tick();
        n_vec++; if (out_valid !== 1'b0 || out_char !== 8'h00) begin n_err++; $display("FAIL row41_end: got %h/%b expected 00/0", out_char, out_valid); end
    endtask

    task automatic test_end_row();
        int  n;
        logic ok;
        dack = 1'b1; n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            if (drq) begin
                dma_data = (n < 5) ? 8'h42 : 8'hF1;
                n++;
            end
            tick();
        end
        dack = 1'b0;
        n_vec++; if (n !== 6) begin n_err++; $display("FAIL eor_count: got %0d expected 6", n); end
        ok = 1'b1;
        repeat (20) begin
            if (drq !== 1'b0) ok = 1'b0;
            tick();
        end
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL eor_drq_low: got %b expected 1", ok); end
        pulse_hrst(10);
        n_vec++; if (rdata[1] !== 1'b0) begin n_err++; $display("FAIL eor_underrun: got %b expected 0", rdata[1]); end
        for (int col = 0; col < 80; col++) begin
            logic [7:0] exp;
            exp = (col < 5) ? 8'h42 : 8'h00;
            tick();
            n_vec++;
            if (out_char !== exp || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL eor_row col %0d: got %h/%b expected %h/1", col, out_char, out_valid, exp);
            end
        end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL eor_row_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_underrun();
        pulse_hrst(10);
        n_vec++; if (rdata[1] !== 1'b1) begin n_err++; $display("FAIL underrun_set: got %b expected 1", rdata[1]); end
        do_rd();
        n_vec++; if (rdata !== 8'h44) begin n_err++; $display("FAIL underrun_clr: got %h expected 44", rdata); end
        n_vec++; if (out_char !== 8'h00 || out_valid !== 1'b1) begin n_err++; $display("FAIL underrun_col0: got %h/%b expected 00/1", out_char, out_valid); end
    endtask

    task automatic test_cmd_irq_err();
        n_vec++; if (drq !== 1'b1) begin n_err++; $display("FAIL pre_rst_drq: got %b expected 1", drq); end
        cpu_wr(1'b1, 8'h00);
        n_vec++; if (drq !== 1'b0) begin n_err++; $display("FAIL cmdrst_drq: got %b expected 0", drq); end
        n_vec++; if (rdata[2] !== 1'b0) begin n_err++; $display("FAIL cmdrst_en: got %b expected 0", rdata[2]); end
        cpu_wr(1'b0, 8'h4F);
        cpu_wr(1'b0, 8'h01);
        cpu_wr(1'b0, 8'h00);
        cpu_wr(1'b0, 8'h02);
        cpu_wr(1'b1, 8'h20);
        pulse_vrst();
        pulse_hrst(2);
        n_vec++; if (rdata[5] !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b expected 0", rdata[5]); end
        pulse_hrst(1);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", irq); end
        n_vec++; if (rdata[5] !== 1'b1) begin n_err++; $display("FAIL irq_status: got %b expected 1", rdata[5]); end
        do_rd();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clr: got %b expected 0", irq); end
        cpu_wr(1'b0, 8'h11);
        cpu_wr(1'b0, 8'h22);
        n_vec++; if (rdata[3] !== 1'b1) begin n_err++; $display("FAIL err_set: got %b expected 1", rdata[3]); end
        pulse_vrst();
        pulse_hrst(2);
        rd = 1'b1; hrst = 1'b1;
        tick();
        rd = 1'b0; hrst = 1'b0;
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
    endtask

    task automatic test_dma_pacing();
        pulse_vrst();
        dack = 1'b1; dma_data = 8'h41;
`ifdef CRTC_BURST_EN
        for (int i = 0; i < 13; i++) begin
            logic exp;
            exp = (i < 4) || (i == 12);
            n_vec++;
            if (drq !== exp) begin n_err++; $display("FAIL burst_drq step %0d: got %b expected %b", i, drq, exp); end
            tick();
        end
`else
        for (int i = 0; i < 6; i++) begin
            logic exp;
            exp = (i % 2) == 0;
            n_vec++;
            if (drq !== exp) begin n_err++; $display("FAIL single_drq step %0d: got %b expected %b", i, drq, exp); end
            tick();
        end
`endif
        dack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_program();
        test_fill_display();
        test_end_row();
        test_underrun();
        test_cmd_irq_err();
        test_dma_pacing();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/crtc_row_fetch.md
CRTC_ROW_FETCH -- requirements
Module: crtc_row_fetch

Interface
REQ-001 SHALL have parameter MAX_COLS, default 80, meaning row-buffer depth per bank in characters (≤128).
REQ-002 SHALL have parameter MAX_ROWS, default 64, meaning maximum programmable character rows.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port char_ce, input, 1, character-slot clock enable; fetch and display logic advance only when it is high.
REQ-006 SHALL have port hrst / vrst, input, 1 each, single-char_ce row-start and frame-start pulses from the timing generator.
REQ-007 SHALL have port a0, input, 1, 1 = command, 0 = parameter.
REQ-008 SHALL have ports wdata (input, 8), we (input, 1), rd (input, 1) and rdata (output, 8): CPU write data, write strobe, status-read strobe and status byte.
REQ-009 SHALL have ports drq (output, 1), dack (input, 1) and dma_data (input, 8): DMA request, acknowledge and byte.
REQ-010 SHALL have ports irq (output, 1), out_char (output, 8), out_attr (output, 6), out_line (output, 4) and out_valid (output, 1).

Function
REQ-011 SHALL decode commands wdata[7:5] on a we cycle: 000 reset (disable, expect 4 params); 001 start (enable, inte=1); 010 stop; 100 load cursor (2 params); 101 inte=1; 110 inte=0; others ignored.
REQ-012 SHALL store params in order: cols-1 [6:0], rows-1 [5:0], charheight-1 [3:0], burst code [2:0]; cursor x then y. A parameter with no pending sequence sets err.
REQ-013 SHALL assert rdata = {0, inte, irq, 0, err, enable, underrun, 0} combinationally; on the cycle after rd, irq, err and underrun clear.
REQ-014 SHALL hold two row banks; fill bank = NOT display bank; banks swap on the hrst that wraps chline to 0.
REQ-015 SHALL assert drq when enable AND fill index ≤ cols-1 AND row/frame not terminated AND rows remaining; a byte is taken on char_ce with drq AND dack, and the index increments.
REQ-016 SHALL treat byte 0xF1 as end-of-row (fill stops, rest displays 0x00) and 0xF3 as end-of-frame (no fill until vrst).
REQ-017 SHALL set underrun if, at swap, the fill index < cols and no end code was received; unfilled slots display 0x00.
REQ-018 SHALL, on each char_ce after hrst, output the display bank at index 0..cols-1 with out_valid=1, then 0x00 with out_valid=0; a byte with [7:6]=10 loads out_attr[5:0] and outputs 0x00.
REQ-019 SHALL count chline 0..charheight on out_line, wrapping at charheight; vrst clears chline, row count, indices, attr and termination flags in the same cycle.
REQ-020 SHALL set irq on the row wrap of the last row when inte=1; on a simultaneous rd and set event, set wins.
REQ-021 SHALL, on a reset command mid-frame, drop drq on the next cycle and discard partial rows.

Reset
REQ-022 SHALL, on reset, clear all registers: drq=0, irq=0, rdata=0x00, out_char=0, out_attr=0, out_line=0, out_valid=0, enable=0 and banks index 0; buffer contents are don't-care.

Configuration
REQ-023 SHALL, with CRTC_BURST_EN defined, hold drq for 2^burst-code consecutive transfers and then wait 8 char_ce before re-requesting; without it, drq deasserts after every transfer for one char_ce and the burst parameter is stored but ignored.

Structure
REQ-024 SHALL place the command enum, parameter-sequencer state enum, end-code constants (0xF1, 0xF3) and the status bit positions in package crtc_pkg.
REQ-025 SHALL implement the dual-bank storage as sub-module crtc_rowbuf (one write port, one read port, bank select).

Verification
REQ-026 SHALL cover: cmd 0x00 plus params 0x4F, 0x1D, 0x99, 0x03 and then 0x20 → enable=1, drq rises within 1 char_ce.
REQ-027 SHALL cover: feed 80 bytes 0x41 → the next row shows 80 × out_char 0x41 with out_valid=1, then out_valid=0.
REQ-028 SHALL cover: byte 0xF1 at column 5 → columns 5-79 show 0x00, drq low for the rest of the row, underrun=0.
REQ-029 SHALL cover: withholding dack for the whole row → underrun=1 after the swap; rd → underrun=0 next cycle.
REQ-030 SHALL cover: the last row wraps with inte=1 → irq=1; a 6th parameter write → err=1.
REQ-031 SHALL cover, with CRTC_BURST_EN and burst code 2: drq is high for 4 transfers and then low for 8 char_ce.
